fifo_pkt_arbiter: RTL and testbench

FIFO_PKT_ARBITER -- requirements
Module: fifo_pkt_arbiter

---
 rtl/fifo_pkt_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_pkt_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_arbiter.sv
// Two-source round-robin packet arbiter writing a store-and-forward FIFO; zero-cycle data path, one IDLE cycle between packets.
// Backpressure: fifo_tready passes straight to the granted source; oversized packets are cut at MAX_PKT_LEN and their tail drained.
module fifo_pkt_arbiter #(
  parameter int DATA_W      = 8,
  parameter int MAX_PKT_LEN = 16,
  parameter int CNT_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] fifo_tdata,
  output logic              fifo_tvalid,
  output logic              fifo_tlast,
  output logic              fifo_w_en,
  input  logic              fifo_tready,
  output logic              fifo_r_en,
  input  logic              m_valid,
  input  logic              m_ready,
  input  logic              m_last,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              trunc_err
);

  localparam int BW = $clog2(MAX_PKT_LEN);
  localparam logic [BW-1:0]    LAST_IDX = BW'(MAX_PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic            last_s1;
  logic [BW-1:0]   beat_cnt;

  logic              sel_s1;
  logic              src_vld;
  logic              src_last;
  logic [DATA_W-1:0] src_dat;
  logic              at_max;
  logic              accept;
  logic              flush_done;
  logic              wr_last;
  logic              rd_last;
  logic              pick_s1;

  always_comb begin
    sel_s1   = grant[1];
    src_vld  = sel_s1 ? s1_tvalid : s0_tvalid;
    src_last = sel_s1 ? s1_tlast  : s0_tlast;
    src_dat  = sel_s1 ? s1_tdata  : s0_tdata;
    at_max   = (beat_cnt == LAST_IDX);

    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    fifo_tvalid = 1'b0;
    fifo_tlast  = 1'b0;
    fifo_tdata  = '0;
    case (state)
      GRANT: begin
        fifo_tvalid = src_vld;
        fifo_tdata  = src_dat;
        // The last beat that fits is always marked so the FIFO never holds an unterminated packet.
        fifo_tlast  = src_last | at_max;
        s0_tready   = ~sel_s1 & fifo_tready;
        s1_tready   = sel_s1 & fifo_tready;
      end
      FLUSH: begin
        s0_tready = ~sel_s1;
        s1_tready = sel_s1;
      end
      default: ;
    endcase
  end

  assign accept     = fifo_tvalid & fifo_tready;
  assign flush_done = (state == FLUSH) & src_vld & src_last;
  assign wr_last    = accept & fifo_tlast;
  assign rd_last    = m_valid & m_ready & m_last;
  // s1 wins when alone, or on contention when s0 was served last.
  assign pick_s1    = s1_tvalid & (~s0_tvalid | ~last_s1);

  assign fifo_w_en = fifo_tvalid;
  assign fifo_r_en = (pkt_cnt != '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      last_s1   <= 1'b1;
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
      trunc_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (s0_tvalid | s1_tvalid) begin
            grant   <= pick_s1 ? 2'b10 : 2'b01;
            last_s1 <= pick_s1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            if (fifo_tlast) begin
              beat_cnt <= '0;
              if (at_max & ~src_last) begin
                trunc_err <= 1'b1;
                state     <= FLUSH;
              end else begin
                grant <= 2'b00;
                state <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_done) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_last & ~rd_last) begin
        pkt_cnt <= pkt_cnt + CNT_ONE;
      end else if (rd_last & ~wr_last) begin
        pkt_cnt <= pkt_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// Directed bench for fifo_pkt_arbiter: round-robin, truncation, stall, same-cycle count, drain and mid-packet reset.
module tb_fifo_pkt_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  s0_tdata, s1_tdata;
  logic        s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
  logic        s0_tready, s1_tready;
  logic [7:0]  fifo_tdata;
  logic        fifo_tvalid, fifo_tlast, fifo_w_en, fifo_tready, fifo_r_en;
  logic        m_valid, m_ready, m_last;
  logic [1:0]  grant;
  logic        busy;
  logic [11:0] pkt_cnt;
  logic        trunc_err;

  int tests = 0;
  int fails = 0;

  fifo_pkt_arbiter #(.DATA_W(8), .MAX_PKT_LEN(16), .CNT_W(12)) dut (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid), .fifo_tlast(fifo_tlast),
    .fifo_w_en(fifo_w_en), .fifo_tready(fifo_tready), .fifo_r_en(fifo_r_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt), .trunc_err(trunc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat from source src, check the write side, then clock it.
  task automatic beat(input int src, input logic [7:0] d, input logic l, input logic ev,
                      input logic el, input logic [1:0] eg, input string tag);
    logic own_rdy, oth_rdy;
    if (src == 1) begin
      s1_tdata = d; s1_tlast = l;
    end else begin
      s0_tdata = d; s0_tlast = l;
    end
    #1;
    own_rdy = (src == 1) ? s1_tready : s0_tready;
    oth_rdy = (src == 1) ? s0_tready : s1_tready;
    check({tag, "_vld"}, fifo_tvalid, ev);
    check({tag, "_wen"}, fifo_w_en, ev);
    if (ev) begin
      check({tag, "_dat"}, fifo_tdata, d);
      check({tag, "_last"}, fifo_tlast, el);
    end
    check({tag, "_rdy"}, own_rdy, 1'b1);
    check({tag, "_oth_rdy"}, oth_rdy, 1'b0);
    check({tag, "_grant"}, grant, eg);
    tick();
  endtask

  initial begin
    logic [1:0] eg;
    logic [7:0] d;

    reset = 1'b1;
    s0_tdata = '0; s1_tdata = '0;
    s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0;
    fifo_tready = 1'b1;
    m_valid = 0; m_ready = 0; m_last = 0;
    tick();
    tick();

    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_trunc", trunc_err, 1'b0);
    check("rst_r_en", fifo_r_en, 1'b0);
    check("rst_s0_rdy", s0_tready, 1'b0);
    check("rst_s1_rdy", s1_tready, 1'b0);
    check("rst_vld", fifo_tvalid, 1'b0);
    check("rst_wen", fifo_w_en, 1'b0);

    // Both sources contend with 16-beat packets: s0, s1, s0.
    reset = 1'b0;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      eg = (p == 1) ? 2'b10 : 2'b01;
      tick();
      check("rr_grant", grant, eg);
      check("rr_busy", busy, 1'b1);
      for (int b = 0; b < 16; b++) begin
        d = 8'(b) | ((p == 1) ? 8'h80 : 8'h00);
        beat((p == 1) ? 1 : 0, d, b == 15, 1'b1, b == 15, eg, "rr");
      end
      check("rr_pkt_cnt", pkt_cnt, p + 1);
      check("rr_idle", busy, 1'b0);
      check("rr_grant_idle", grant, 2'b00);
      check("rr_r_en", fifo_r_en, 1'b1);
    end
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;

    // Drain three stored packets.
    m_valid = 1'b1; m_ready = 1'b1; m_last = 1'b0;
    tick();
    check("drain_nolast", pkt_cnt, 3);
    m_last = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      check("drain_r_en_pre", fifo_r_en, 1'b1);
      tick();
      check("drain_cnt", pkt_cnt, k);
    end
    check("drain_r_en_off", fifo_r_en, 1'b0);
    m_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;

    // 20-beat packet from s0 is cut at 16; s1 requesting meanwhile must not steal the grant.
    s0_tvalid = 1'b1;
    tick();
    check("tr_grant", grant, 2'b01);
    for (int b = 0; b < 20; b++) begin
      if (b == 5) s1_tvalid = 1'b1;
      if (b == 15) check("tr_err_pre", trunc_err, 1'b0);
      beat(0, 8'(8'h20 + b), b == 19, b < 16, b == 15, 2'b01, "trunc");
      if (b == 15) begin
        check("tr_err_set", trunc_err, 1'b1);
        check("tr_pkt_cnt", pkt_cnt, 1);
        check("tr_busy_flush", busy, 1'b1);
      end
    end
    check("tr_idle", busy, 1'b0);
    check("tr_grant_idle", grant, 2'b00);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;

    // Write-last and read-last in the same cycle with one packet stored.
    s1_tvalid = 1'b1;
    tick();
    check("same_grant", grant, 2'b10);
    beat(1, 8'hA0, 1'b0, 1'b1, 1'b0, 2'b10, "same");
    beat(1, 8'hA1, 1'b0, 1'b1, 1'b0, 2'b10, "same");
    m_valid = 1'b1; m_ready = 1'b1; m_last = 1'b1;
    check("same_cnt_pre", pkt_cnt, 1);
    beat(1, 8'hA2, 1'b1, 1'b1, 1'b1, 2'b10, "same");
    check("same_cnt", pkt_cnt, 1);
    check("same_r_en", fifo_r_en, 1'b1);
    m_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
    s1_tvalid = 1'b0;

    // FIFO full for five cycles in the middle of an 8-beat packet.
    s0_tvalid = 1'b1;
    tick();
    check("stall_grant", grant, 2'b01);
    for (int b = 0; b < 3; b++) beat(0, 8'(8'h40 + b), 1'b0, 1'b1, 1'b0, 2'b01, "stall");
    fifo_tready = 1'b0;
    s0_tdata = 8'h43;
    s0_tlast = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_s0_rdy", s0_tready, 1'b0);
      check("stall_dat", fifo_tdata, 8'h43);
      check("stall_vld", fifo_tvalid, 1'b1);
      check("stall_beat_cnt", dut.beat_cnt, 3);
      check("stall_busy", busy, 1'b1);
      tick();
    end
    fifo_tready = 1'b1;
    for (int b = 3; b < 8; b++) beat(0, 8'(8'h40 + b), b == 7, 1'b1, b == 7, 2'b01, "stall");
    check("stall_pkt_cnt", pkt_cnt, 2);
    check("stall_trunc_sticky", trunc_err, 1'b1);
    check("stall_idle", busy, 1'b0);

    // Reset on beat 7 of an s0 packet; s0 must still win the first contention after it.
    tick();
    check("mrst_grant", grant, 2'b01);
    for (int b = 0; b < 6; b++) beat(0, 8'(8'h60 + b), 1'b0, 1'b1, 1'b0, 2'b01, "mrst");
    s0_tdata = 8'h66;
    s1_tvalid = 1'b1;
    reset = 1'b1;
    tick();
    check("mrst_grant_rst", grant, 2'b00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_pkt_cnt", pkt_cnt, 0);
    check("mrst_trunc", trunc_err, 1'b0);
    check("mrst_beat_cnt", dut.beat_cnt, 0);
    check("mrst_r_en", fifo_r_en, 1'b0);
    check("mrst_s0_rdy", s0_tready, 1'b0);
    check("mrst_s1_rdy", s1_tready, 1'b0);
    check("mrst_vld", fifo_tvalid, 1'b0);
    check("mrst_wen", fifo_w_en, 1'b0);
    reset = 1'b0;
    tick();
    check("mrst_first_grant", grant, 2'b01);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
